fix2flt_engine: RTL and testbench

//  Hardware converter from signed fixed 8.8 (two's complement) to IEEE half-precision float.

---
 rtl/fix2flt_pkg.sv | 43 ++++
 rtl/fix2flt_norm.sv | 56 +++++
 rtl/fix2flt_engine.sv | 147 ++++++++++++++
 tb/tb_fix2flt_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fix2flt_pkg.sv
// ---------------------------------------------------------------------------
// fix2flt_pkg
// Shared definitions for the signed fixed 8.8 to IEEE half-precision
// converter: controller state encoding, float16 field widths, the starting
// exponent and small helper functions used by the top and the normalizer.
// ---------------------------------------------------------------------------
package fix2flt_pkg;

  // Controller states in the order one conversion walks through them
  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    RD_HI,
    NEG,
    NORM,
    PACK,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam int FLT_BIAS = 15;
  localparam int FIX_FRAC = 8;
  // A magnitude whose leading one sits in bit 15 is worth 2^(15-FIX_FRAC),
  // so that is the biased exponent before any normalizing shift.
  localparam int EXP_INIT = FLT_BIAS + 15 - FIX_FRAC;
  localparam int MANT_W   = 10;
  localparam int EXP_W    = 5;
  localparam int DATA_W   = 16;

  // Two's complement magnitude; 0x8000 maps onto itself, which read as
  // unsigned is exactly 32768.
  function automatic logic [DATA_W-1:0] abs_fix(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 16'd1) : x;
  endfunction

  function automatic logic [DATA_W-1:0] pack_half(input logic              sign,
                                                  input logic [EXP_W-1:0]  exp,
                                                  input logic [MANT_W-1:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/fix2flt_norm.sv
// ---------------------------------------------------------------------------
// fix2flt_norm
// Serial normalizer: holds the operand magnitude and its running exponent,
// shifting left one bit per enabled cycle until the leading one reaches
// bit 15.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   load        : capture load_val and reset the exponent to EXP_INIT
//   shift_en    : shift the magnitude left by one and decrement exponent
//   load_val    : magnitude to be normalized
//   load_done   : load_val needs no shifting (zero or bit 15 already set)
//   shift_done  : the shift happening this cycle leaves bit 15 set
//   is_zero     : held magnitude is zero
//   mant        : fraction bits below the hidden one (truncated)
//   exp_cnt     : biased exponent matching the held magnitude
// ---------------------------------------------------------------------------
module fix2flt_norm
  import fix2flt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] load_val,
  output logic              load_done,
  output logic              shift_done,
  output logic              is_zero,
  output logic [MANT_W-1:0] mant,
  output logic [EXP_W-1:0]  exp_cnt
);

  logic [DATA_W-1:0] mag;

  // Magnitude shift register and exponent counter move together so the
  // exponent always describes the value currently held in mag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag     <= '0;
      exp_cnt <= '0;
    end else if (load) begin
      mag     <= load_val;
      exp_cnt <= EXP_W'(EXP_INIT);
    end else if (shift_en) begin
      mag     <= {mag[DATA_W-2:0], 1'b0};
      exp_cnt <= exp_cnt - 1'b1;
    end
  end

  // Looking one bit ahead lets the controller leave NORM on the very edge
  // that completes normalization instead of one cycle later.
  assign load_done  = (load_val == '0) || load_val[DATA_W-1];
  assign shift_done = mag[DATA_W-2];
  assign is_zero    = (mag == '0);
  assign mant       = mag[DATA_W-2 -: MANT_W];

endmodule

// File: rtl/fix2flt_engine.sv
// ---------------------------------------------------------------------------
// fix2flt_engine
// Converts a signed fixed 8.8 operand held in byte memory into an IEEE
// half-precision float (mantissa truncated, zero always +0) and writes the
// result back to the same memory, then raises ack.
// Parameters:
//   IN_ADDR  : byte address of operand low byte (high byte at IN_ADDR+1)
//   OUT_ADDR : byte address of result low byte (high byte at OUT_ADDR+1)
//   AW       : data memory address width
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : conversion request, honoured in IDLE and DONE only
//   ack         : conversion complete, held until next accepted start
//   mem_addr    : data memory byte address
//   mem_rd_data : combinational read data for mem_addr
//   mem_wr_data : data memory write data
//   mem_we      : write enable, memory writes on the rising edge
// ---------------------------------------------------------------------------
module fix2flt_engine
  import fix2flt_pkg::*;
#(
  parameter int IN_ADDR  = 4,
  parameter int OUT_ADDR = 6,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          ack,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [7:0]    mem_wr_data,
  output logic          mem_we
);

  localparam logic [AW-1:0] IN_LO  = AW'(IN_ADDR);
  localparam logic [AW-1:0] IN_HI  = AW'(IN_ADDR + 1);
  localparam logic [AW-1:0] OUT_LO = AW'(OUT_ADDR);
  localparam logic [AW-1:0] OUT_HI = AW'(OUT_ADDR + 1);

  state_t            state;
  logic [7:0]        x_lo;
  logic [7:0]        x_hi;
  logic              sign;
  logic [7:0]        result_hi;

  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] mag_in;
  logic [DATA_W-1:0] pack_value;
  logic              norm_load;
  logic              norm_shift;
  logic              load_done;
  logic              shift_done;
  logic              is_zero;
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  exp_cnt;

  assign x          = {x_hi, x_lo};
  assign mag_in     = abs_fix(x);
  assign norm_load  = (state == NEG);
  assign norm_shift = (state == NORM);
  // Zero is forced to +0 so a negative-zero pattern can never be produced.
  assign pack_value = is_zero ? '0 : pack_half(sign, exp_cnt, mant);

  fix2flt_norm u_norm (
    .clk        (clk),
    .reset      (reset),
    .load       (norm_load),
    .shift_en   (norm_shift),
    .load_val   (mag_in),
    .load_done  (load_done),
    .shift_done (shift_done),
    .is_zero    (is_zero),
    .mant       (mant),
    .exp_cnt    (exp_cnt)
  );

  // Controller: sequences the two operand reads, the normalization and the
  // two result writes. Memory address/data/enable are registered so each
  // state presents them for its whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ack         <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_we      <= 1'b0;
      x_lo        <= '0;
      x_hi        <= '0;
      sign        <= 1'b0;
      result_hi   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          mem_we <= 1'b0;
          if (start) begin
            ack      <= 1'b0;
            mem_addr <= IN_LO;
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          x_lo     <= mem_rd_data;
          mem_addr <= IN_HI;
          state    <= RD_HI;
        end
        RD_HI: begin
          x_hi  <= mem_rd_data;
          state <= NEG;
        end
        NEG: begin
          sign  <= x[DATA_W-1];
          state <= load_done ? PACK : NORM;
        end
        NORM: begin
          if (shift_done) begin
            state <= PACK;
          end
        end
        PACK: begin
          result_hi   <= pack_value[15:8];
          mem_addr    <= OUT_LO;
          mem_wr_data <= pack_value[7:0];
          mem_we      <= 1'b1;
          state       <= WR_LO;
        end
        WR_LO: begin
          mem_addr    <= OUT_HI;
          mem_wr_data <= result_hi;
          mem_we      <= 1'b1;
          state       <= WR_HI;
        end
        WR_HI: begin
          mem_we <= 1'b0;
          ack    <= 1'b1;
          state  <= DONE;
        end
        default: begin
          state  <= IDLE;
          ack    <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fix2flt_engine.sv
// ---------------------------------------------------------------------------
// tb_fix2flt_engine
// Byte-memory model around fix2flt_engine; checks results, latency and
// write counts against a reference model of fixed 8.8 to float16.
// ---------------------------------------------------------------------------
module tb_fix2flt_engine;

  localparam int IN_ADDR  = 4;
  localparam int OUT_ADDR = 6;
  localparam int AW       = 8;
  localparam int WAIT_MAX = 60;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          ack;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic [7:0]    mem_wr_data;
  logic          mem_we;

  logic [7:0]    mem [0:255];
  logic          tb_we;
  logic [AW-1:0] tb_addr;
  logic [7:0]    tb_data;
  int            we_count = 0;

  int total = 0;
  int bad   = 0;

  fix2flt_engine #(
    .IN_ADDR  (IN_ADDR),
    .OUT_ADDR (OUT_ADDR),
    .AW       (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_data (mem_wr_data),
    .mem_we      (mem_we)
  );

  always #5 clk = ~clk;

  // Memory: DUT writes take priority; the bench loads operands only while
  // the DUT is not writing.
  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wr_data;
      we_count      <= we_count + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end
  end

  // Reference: value = x / 256, written as 1.f * 2^e with f truncated.
  function automatic logic [15:0] ref_half(input logic [15:0] x);
    int  v;
    int  e;
    int  m;
    real a;
    logic s;
    logic [4:0] ef;
    logic [9:0] mf;
    v = int'($signed(x));
    if (v == 0) return 16'h0000;
    s = (v < 0);
    a = (s ? -v : v) / 256.0;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m  = $rtoi((a - 1.0) * 1024.0);
    ef = 5'(e + 15);
    mf = 10'(m);
    return {s, ef, mf};
  endfunction

  // Reference latency: 6 cycles plus one shift per bit the leading one sits
  // below bit 15.
  function automatic int ref_latency(input logic [15:0] x);
    int v;
    int p;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v == 0) return 6;
    p = $clog2(v + 1) - 1;
    return 6 + (15 - p);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic pokeByte(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_addr = a;
    tb_data = d;
    tb_we   = 1'b1;
    @(negedge clk);
    tb_we   = 1'b0;
  endtask

  // One conversion; poke_cycle >= 0 re-asserts start for one cycle at that
  // point of the run.
  task automatic applyStimulus(input logic [15:0] operand, input int poke_cycle,
                               output logic [15:0] result, output int cycles,
                               output int writes);
    int w0;
    pokeByte(AW'(IN_ADDR), operand[7:0]);
    pokeByte(AW'(IN_ADDR + 1), operand[15:8]);
    w0 = we_count;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("ack_drop", ack, 1'b0);
    cycles = 0;
    while (ack !== 1'b1 && cycles < WAIT_MAX) begin
      start = (cycles == poke_cycle);
      @(posedge clk);
      #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput("ack_seen", ack, 1'b1);
    writes = we_count - w0;
    result = {mem[OUT_ADDR + 1], mem[OUT_ADDR]};
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] op;
    int cyc;
    int wr;
    int w0;

    $display("[TB] fix2flt_engine test start");
    reset = 1'b1;
    start = 1'b0;
    tb_we = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ack", ack, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 8'h00);
    checkOutput("rst_wdata", mem_wr_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(16'h0100, -1, res, cyc, wr);
    checkOutput("one_res", res, 16'h3C00);
    checkOutput("one_lat", cyc, 13);
    checkOutput("one_wr", wr, 2);

    applyStimulus(16'h0180, -1, res, cyc, wr);
    checkOutput("onehalf_res", res, 16'h3E00);
    checkOutput("onehalf_lat", cyc, 13);

    applyStimulus(16'hFF00, -1, res, cyc, wr);
    checkOutput("mone_res", res, 16'hBC00);

    applyStimulus(16'h8000, -1, res, cyc, wr);
    checkOutput("m128_res", res, 16'hD800);
    checkOutput("m128_lat", cyc, 6);

    applyStimulus(16'h0000, -1, res, cyc, wr);
    checkOutput("zero_res", res, 16'h0000);
    checkOutput("zero_lat", cyc, 6);
    checkOutput("zero_wr", wr, 2);

    applyStimulus(16'h0001, -1, res, cyc, wr);
    checkOutput("lsb_res", res, 16'h1C00);
    checkOutput("lsb_lat", cyc, 21);

    applyStimulus(16'h7FFF, -1, res, cyc, wr);
    checkOutput("max_res", res, 16'h57FF);

    // Start pulse while normalizing must be ignored
    applyStimulus(16'h0001, 6, res, cyc, wr);
    checkOutput("poke_res", res, 16'h1C00);
    checkOutput("poke_lat", cyc, 21);
    checkOutput("poke_wr", wr, 2);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("poke_noretrig", ack, 1'b1);

    // Reset while normalizing aborts without any write
    pokeByte(AW'(IN_ADDR), 8'h80);
    pokeByte(AW'(IN_ADDR + 1), 8'h01);
    pokeByte(AW'(OUT_ADDR), 8'hAA);
    pokeByte(AW'(OUT_ADDR + 1), 8'hAA);
    w0 = we_count;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_ack", ack, 1'b0);
    checkOutput("abort_we", mem_we, 1'b0);
    checkOutput("abort_addr", mem_addr, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_idle", ack, 1'b0);
    checkOutput("abort_writes", we_count - w0, 0);
    checkOutput("abort_mem", {mem[OUT_ADDR + 1], mem[OUT_ADDR]}, 16'hAAAA);

    applyStimulus(16'h0180, -1, res, cyc, wr);
    checkOutput("rerun_res", res, 16'h3E00);
    checkOutput("rerun_lat", cyc, 13);

    // Random operands against the reference model
    for (int i = 0; i < 1200; i++) begin
      op = 16'($urandom);
      if (i % 4 == 0) op = {8'h00, op[7:0]} >> op[11:8];
      applyStimulus(op, -1, res, cyc, wr);
      checkOutput("rand_res", res, ref_half(op));
      checkOutput("rand_lat", cyc, ref_latency(op));
      checkOutput("rand_wr", wr, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
